// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline buffer registers and their sequencing controller.
package Pipe_Buf_Reg_PKG;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      TIMEOUT  = 2'd2
   } pipe_ctrl_state_e;

   // Per-stage load enables and bubble flushes; a set flush bit wins over its enable.
   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic id_ex_en;
      logic ex_mem_en;
      logic mem_wb_en;
      logic if_id_flush;
      logic id_ex_flush;
      logic ex_mem_flush;
      logic mem_wb_flush;
   } pipe_ctrl_s;

   localparam pipe_ctrl_s CTRL_NORMAL = 9'b11111_0000;
   localparam pipe_ctrl_s CTRL_RESET  = 9'b00000_1111;
   localparam pipe_ctrl_s CTRL_HALT   = 9'b00000_0000;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use detector: a load in EX whose rd feeds a source actually read by the ID instruction.
module hazard_detect (
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_uses_rs1,
   input  logic       id_uses_rs2,
   input  logic       ex_memread,
   input  logic [4:0] ex_rd,
   output logic       load_use
);

   // x0 is never a real dependency, so a load targeting it cannot cause a stall.
   assign load_use = ex_memread && (ex_rd != 5'd0) &&
                     ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                      (id_uses_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: hazard priority mux, memory-wait FSM and statistics.
module pipe_ctrl
   import Pipe_Buf_Reg_PKG::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             ex_memread,
   input  logic [4:0]       ex_rd,
   input  logic             ex_redirect,
   input  logic             mem_req,
   input  logic             dmem_ready,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_flush,
   output logic             mem_wb_flush,
   output logic             mem_timeout_err,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

   pipe_ctrl_state_e  state, next_state;
   logic [WAIT_W-1:0] wait_cnt, next_wait_cnt;
   pipe_ctrl_s        ctrl, ctrl_out;
   logic              load_use;
   logic              mem_hold;
   logic              stall_inc;
   logic              flush_inc;

   hazard_detect u_hazard_detect (
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_uses_rs1 (id_uses_rs1),
      .id_uses_rs2 (id_uses_rs2),
      .ex_memread  (ex_memread),
      .ex_rd       (ex_rd),
      .load_use    (load_use)
   );

   assign mem_hold = mem_req && !dmem_ready;

   // State and wait counter registers; reset forces RUN with an empty wait count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         wait_cnt <= '0;
      end else begin
         state    <= next_state;
         wait_cnt <= next_wait_cnt;
      end
   end

   // Priority mux (memory hold > redirect > load-use) and memory-wait transitions.
   always_comb begin
      next_state    = state;
      next_wait_cnt = wait_cnt;
      ctrl          = CTRL_NORMAL;
      stall_inc     = 1'b0;
      flush_inc     = 1'b0;
      case (state)
         RUN, MEM_WAIT: begin
            if (mem_hold) begin
               ctrl.pc_en        = 1'b0;
               ctrl.if_id_en     = 1'b0;
               ctrl.id_ex_en     = 1'b0;
               ctrl.ex_mem_en    = 1'b0;
               ctrl.mem_wb_flush = 1'b1;
               stall_inc         = 1'b1;
            end else if (ex_redirect) begin
               ctrl.if_id_flush  = 1'b1;
               ctrl.id_ex_flush  = 1'b1;
               flush_inc         = 1'b1;
            end else if (load_use) begin
               ctrl.pc_en        = 1'b0;
               ctrl.if_id_en     = 1'b0;
               ctrl.id_ex_flush  = 1'b1;
               stall_inc         = 1'b1;
            end
            if (state == RUN) begin
               if (mem_hold) begin
                  next_state    = MEM_WAIT;
                  next_wait_cnt = WAIT_W'(1);
               end
            end else if (!mem_req || dmem_ready) begin
               next_state    = RUN;
               next_wait_cnt = '0;
            end else if (wait_cnt < WAIT_MAX) begin
               next_wait_cnt = wait_cnt + WAIT_W'(1);
            end else begin
               next_state = TIMEOUT;
            end
         end
         TIMEOUT: begin
            ctrl = CTRL_HALT;
         end
         default: begin
            next_state    = RUN;
            next_wait_cnt = '0;
         end
      endcase
   end

   // Reset overrides everything so every buffer register loads a bubble while rst_n is low.
   always_comb begin
      ctrl_out = rst_n ? ctrl : CTRL_RESET;
   end

   assign pc_en           = ctrl_out.pc_en;
   assign if_id_en        = ctrl_out.if_id_en;
   assign id_ex_en        = ctrl_out.id_ex_en;
   assign ex_mem_en       = ctrl_out.ex_mem_en;
   assign mem_wb_en       = ctrl_out.mem_wb_en;
   assign if_id_flush     = ctrl_out.if_id_flush;
   assign id_ex_flush     = ctrl_out.id_ex_flush;
   assign ex_mem_flush    = ctrl_out.ex_mem_flush;
   assign mem_wb_flush    = ctrl_out.mem_wb_flush;
   assign mem_timeout_err = (state == TIMEOUT);

   // Saturating statistics counters; they stick at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         if (stall_inc && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
         end
         if (flush_inc && (flush_events != '1)) begin
            flush_events <= flush_events + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed, table-driven bench for pipe_ctrl; a second instance with 4-bit counters covers saturation.
module tb_pipe_ctrl;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       uses1;
      logic       uses2;
      logic       memread;
      logic [4:0] rd;
      logic       redirect;
      logic       mem_req;
      logic       ready;
   } stim_t;

   typedef struct {
      stim_t      stim;
      logic [8:0] exp;
      logic [8:0] mask;
      int         stall_d;
      int         flush_d;
      string      name;
   } vec_t;

   // Bit order: {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl}
   localparam logic [8:0] C_NORMAL = 9'b11111_0000;
   localparam logic [8:0] C_LU     = 9'b00011_0100;
   localparam logic [8:0] M_LU     = 9'b11011_1111;
   localparam logic [8:0] C_REDIR  = 9'b11111_1100;
   localparam logic [8:0] C_HOLD   = 9'b00000_0001;
   localparam logic [8:0] M_HOLD   = 9'b11110_1111;
   localparam logic [8:0] C_HALT   = 9'b00000_0000;
   localparam logic [8:0] C_RESET  = 9'b00000_1111;
   localparam logic [8:0] M_ALL    = 9'h1FF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
   logic        id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_memread = 1'b0;
   logic        ex_redirect = 1'b0, mem_req = 1'b0, dmem_ready = 1'b0;

   logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mem_timeout_err;
   logic [15:0] stall_cycles, flush_events;

   logic        s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en;
   logic        s_if_id_flush, s_id_ex_flush, s_ex_mem_flush, s_mem_wb_flush, s_err;
   logic [3:0]  s_stall_cycles, s_flush_events;

   logic [8:0]  main_ctrl, sat_ctrl;
   assign main_ctrl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
   assign sat_ctrl  = {s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en,
                       s_if_id_flush, s_id_ex_flush, s_ex_mem_flush, s_mem_wb_flush};

   int total = 0;
   int bad = 0;
   int exp_stall = 0;
   int exp_flush = 0;
   vec_t vecs[11];

   always #5 clk = ~clk;

   pipe_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
      .mem_req(mem_req), .dmem_ready(dmem_ready),
      .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
      .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
      .mem_timeout_err(mem_timeout_err), .stall_cycles(stall_cycles), .flush_events(flush_events)
   );

   pipe_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4)) dut_sat (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
      .mem_req(mem_req), .dmem_ready(dmem_ready),
      .pc_en(s_pc_en), .if_id_en(s_if_id_en), .id_ex_en(s_id_ex_en), .ex_mem_en(s_ex_mem_en),
      .mem_wb_en(s_mem_wb_en), .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
      .ex_mem_flush(s_ex_mem_flush), .mem_wb_flush(s_mem_wb_flush),
      .mem_timeout_err(s_err), .stall_cycles(s_stall_cycles), .flush_events(s_flush_events)
   );

   function automatic stim_t mkStim(input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic u1, input logic u2, input logic mr,
                                    input logic [4:0] rd, input logic redir,
                                    input logic req, input logic rdy);
      stim_t s;
      s.rs1 = rs1; s.rs2 = rs2; s.uses1 = u1; s.uses2 = u2; s.memread = mr;
      s.rd = rd; s.redirect = redir; s.mem_req = req; s.ready = rdy;
      return s;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle of inputs on the falling edge, then let combinational outputs settle.
   task automatic applyStimulus(input stim_t s);
      @(negedge clk);
      id_rs1 = s.rs1; id_rs2 = s.rs2; id_uses_rs1 = s.uses1; id_uses_rs2 = s.uses2;
      ex_memread = s.memread; ex_rd = s.rd; ex_redirect = s.redirect;
      mem_req = s.mem_req; dmem_ready = s.ready;
      #1;
   endtask

   task automatic checkCtrl(input string name, input logic [8:0] exp, input logic [8:0] mask);
      checkOutput({name, "_ctrl"}, 32'(main_ctrl & mask), 32'(exp & mask));
      checkOutput({name, "_sat_ctrl"}, 32'(sat_ctrl & mask), 32'(exp & mask));
   endtask

   task automatic checkCounters(input string name);
      checkOutput({name, "_stall"}, 32'(stall_cycles), 32'(exp_stall));
      checkOutput({name, "_flush"}, 32'(flush_events), 32'(exp_flush));
      checkOutput({name, "_sat_stall"}, 32'(s_stall_cycles), 32'((exp_stall > 15) ? 15 : exp_stall));
   endtask

   task automatic doReset(input string name);
      @(negedge clk);
      rst_n = 1'b0;
      id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
      ex_memread = 1'b0; ex_rd = '0; ex_redirect = 1'b0; mem_req = 1'b0; dmem_ready = 1'b0;
      #1;
      exp_stall = 0;
      exp_flush = 0;
      checkCtrl({name, "_rst"}, C_RESET, M_ALL);
      checkCounters({name, "_rst"});
      checkOutput({name, "_rst_err"}, 32'(mem_timeout_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      stim_t s;
      vecs[0]  = '{mkStim(5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0, 0), C_NORMAL, M_ALL, 0, 0, "idle"};
      vecs[1]  = '{mkStim(5'd5,  5'd0,  1, 0, 1, 5'd5,  0, 0, 0), C_LU,     M_LU,  1, 0, "lu_rs1"};
      vecs[2]  = '{mkStim(5'd5,  5'd0,  1, 0, 0, 5'd5,  0, 0, 0), C_NORMAL, M_ALL, 0, 0, "after_bubble"};
      vecs[3]  = '{mkStim(5'd0,  5'd0,  1, 0, 1, 5'd0,  0, 0, 0), C_NORMAL, M_ALL, 0, 0, "rd_zero"};
      vecs[4]  = '{mkStim(5'd0,  5'd7,  0, 0, 1, 5'd7,  0, 0, 0), C_NORMAL, M_ALL, 0, 0, "rs2_unused"};
      vecs[5]  = '{mkStim(5'd0,  5'd7,  0, 1, 1, 5'd7,  0, 0, 0), C_LU,     M_LU,  1, 0, "lu_rs2"};
      vecs[6]  = '{mkStim(5'd5,  5'd0,  1, 0, 1, 5'd5,  1, 0, 0), C_REDIR,  M_ALL, 0, 1, "redir_lu"};
      vecs[7]  = '{mkStim(5'd0,  5'd0,  0, 0, 0, 5'd0,  1, 0, 0), C_REDIR,  M_ALL, 0, 1, "redirect"};
      vecs[8]  = '{mkStim(5'd3,  5'd0,  1, 0, 1, 5'd4,  0, 0, 0), C_NORMAL, M_ALL, 0, 0, "rs_mismatch"};
      vecs[9]  = '{mkStim(5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 1, 1), C_NORMAL, M_ALL, 0, 0, "mem_ready"};
      vecs[10] = '{mkStim(5'd31, 5'd31, 1, 1, 1, 5'd31, 0, 0, 0), C_LU,     M_LU,  1, 0, "lu_r31"};

      // Reset values while rst_n is held low from time zero.
      #1;
      checkCtrl("por", C_RESET, M_ALL);
      checkCounters("por");
      checkOutput("por_err", 32'(mem_timeout_err), 32'd0);
      doReset("init");

      // Table-driven single-cycle hazard resolution in RUN.
      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].stim);
         checkCtrl(vecs[i].name, vecs[i].exp, vecs[i].mask);
         checkCounters(vecs[i].name);
         exp_stall += vecs[i].stall_d;
         exp_flush += vecs[i].flush_d;
      end
      applyStimulus(mkStim(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0));
      checkCounters("table_end");

      // Redirect together with load-use counts a flush but no stall.
      doReset("rl");
      applyStimulus(mkStim(5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 0, 0));
      checkCtrl("rl_same", C_REDIR, M_ALL);
      applyStimulus(mkStim(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0));
      exp_flush = 1;
      checkCounters("rl_after");

      // Three not-ready cycles with a pending redirect, then release takes the redirect.
      doReset("mw");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(mkStim(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 0));
         checkCtrl($sformatf("mw_freeze%0d", i), C_HOLD, M_HOLD);
         checkCounters($sformatf("mw_freeze%0d", i));
         exp_stall++;
      end
      applyStimulus(mkStim(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 1));
      checkCtrl("mw_release", C_REDIR, M_ALL);
      checkCounters("mw_release");
      exp_flush++;
      applyStimulus(mkStim(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0));
      checkCtrl("mw_run", C_NORMAL, M_ALL);
      checkCounters("mw_run");

      // Timeout: 16 not-ready cycles freeze, then the block halts until reset.
      doReset("to");
      for (int i = 1; i <= 16; i++) begin
         applyStimulus(mkStim(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0));
         checkOutput($sformatf("to_err_c%0d", i), 32'(mem_timeout_err), 32'd0);
         if (i == 1 || i == 16) checkCtrl($sformatf("to_freeze_c%0d", i), C_HOLD, M_HOLD);
         exp_stall++;
      end
      for (int i = 0; i < 4; i++) begin
         s = mkStim(5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 1, (i >= 2) ? 1'b1 : 1'b0);
         applyStimulus(s);
         checkOutput($sformatf("to_err_h%0d", i), 32'(mem_timeout_err), 32'd1);
         checkOutput($sformatf("to_sat_err_h%0d", i), 32'(s_err), 32'd1);
         checkCtrl($sformatf("to_halt_h%0d", i), C_HALT, M_ALL);
         checkCounters($sformatf("to_halt_h%0d", i));
      end
      rst_n = 1'b0;
      #1;
      exp_stall = 0;
      exp_flush = 0;
      checkOutput("to_rst_err", 32'(mem_timeout_err), 32'd0);
      checkCtrl("to_rst", C_RESET, M_ALL);
      checkCounters("to_rst");
      rst_n = 1'b1;
      applyStimulus(mkStim(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0));
      checkCtrl("to_after_rst", C_NORMAL, M_ALL);

      // Saturation: 20 load-use stall cycles on both counter widths.
      doReset("sat");
      for (int i = 0; i < 20; i++) begin
         applyStimulus(mkStim(5'd9, 5'd0, 1, 0, 1, 5'd9, 0, 0, 0));
         exp_stall++;
      end
      applyStimulus(mkStim(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0));
      checkCounters("sat_end");
      checkOutput("sat_flush_small", 32'(s_flush_events), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core. It owns the enable and flush of the PC and of the four pipeline buffer registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It resolves three hazard sources in fixed priority:
- data-memory wait;
- control redirect (branch/JAL/JALR);
- load-use.

It also tracks memory-wait timeouts and keeps saturating stall and flush statistics counters.

## Interface
- MEM_TIMEOUT, 15: maximum consecutive data-memory wait cycles before fatal timeout.
- CNT_W, 16: width of the statistics counters.

- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1 each  the instruction in ID reads that source.
- ex_memread  in  1  MemRead of the ID/EX register.
- ex_rd  in  5  rd of the ID/EX register.
- ex_redirect  in  1  EX resolved taken branch, JAL or JALR.
- mem_req  in  1  MemRead|MemWrite of the EX/MEM register.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register loads on the edge.
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  register loads a bubble (all control bits 0). Flush overrides en.
- mem_timeout_err  out  1  sticky fatal error.
- stall_cycles, flush_events  out  CNT_W each  saturating statistics.

## Operation
- States: RUN, MEM_WAIT, TIMEOUT.
- mem_hold = mem_req && !dmem_ready. It is combinational and is evaluated in RUN and MEM_WAIT.
- load_use = ex_memread && ex_rd != 0 && ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd)).

Priority 1, mem_hold:
- pc_en, if_id_en, id_ex_en and ex_mem_en are 0.
- mem_wb_flush is 1.
- ex_redirect and load_use are ignored this cycle. They remain visible because EX is frozen.

Priority 2, ex_redirect:
- All enables are 1.
- if_id_flush and id_ex_flush are 1.
- flush_events increments.

Priority 3, load_use:
- pc_en and if_id_en are 0.
- id_ex_flush is 1.
- ex_mem_en and mem_wb_en are 1.

Otherwise: all enables are 1 and all flushes are 0.

Statistics:
- stall_cycles increments on every mem_hold or load_use cycle.
- Both counters saturate at all-ones.

State transitions:
- RUN → MEM_WAIT when mem_hold. wait_cnt is set to 1.
- MEM_WAIT with dmem_ready → RUN. wait_cnt is cleared.
- MEM_WAIT with !dmem_ready and wait_cnt < MEM_TIMEOUT: wait_cnt increments.
- MEM_WAIT with !dmem_ready and wait_cnt == MEM_TIMEOUT → TIMEOUT.
- If mem_req drops while in MEM_WAIT (not legal), return to RUN.

TIMEOUT:
- All enables are 0 and all flushes are 0.
- mem_timeout_err is 1.
- The block leaves TIMEOUT only on reset.

## Timing
- Outputs depend combinationally on the current inputs and state. There is zero added latency: a hazard seen in cycle N controls the edge at the end of cycle N.
- A load-use stall lasts exactly 1 cycle, because the bubble clears ex_memread.
- A redirect costs 2 bubbles.
- Memory wait of k cycles:
  - the freeze lasts k cycles;
  - the pipeline advances on the cycle dmem_ready is 1;
  - with MEM_TIMEOUT=15, TIMEOUT is entered on the edge after the 16th consecutive not-ready cycle.
- Simultaneous events:
  - mem_hold together with redirect: freeze only, then the redirect is taken on the release cycle.
  - redirect together with load_use: redirect only, no stall is counted.
- While rst_n is low, independent of clk:
  - state is RUN, wait_cnt is 0;
  - counters are 0, mem_timeout_err is 0;
  - all en outputs are 0 and all flush outputs are 1.
- The first edge after rst_n rises is normal operation.
- Reset asserted mid-wait or in TIMEOUT returns the block to this reset state immediately.

## Structure
- Add to Pipe_Buf_Reg_PKG:
  - pipe_ctrl_state_e enum (RUN, MEM_WAIT, TIMEOUT);
  - pipe_ctrl_s packed struct holding en and flush per stage.
- Sub-module hazard_detect is purely combinational and produces load_use from the ID/EX fields.
- pipe_ctrl holds the FSM, wait_cnt ($clog2(MEM_TIMEOUT+1) bits), the priority mux and the counters.

## Test plan
- Load-use, add in ID with rs1=5, lw rd=5 in EX:
  - expected for 1 cycle: pc_en=0, if_id_en=0, id_ex_flush=1, stall_cycles=1;
  - expected the next cycle: all en=1.
- rd=0 load with rs1=0 in ID → no stall.
- Redirect on the same cycle as load_use:
  - expected: if_id_flush=1, id_ex_flush=1, pc_en=1;
  - expected: flush_events=1, stall_cycles=0.
- mem_req with dmem_ready low for 3 cycles, then high:
  - expected: 3 freeze cycles with mem_wb_flush=1, stall_cycles=3;
  - expected: return to RUN on the 4th cycle.
- Timeout, MEM_TIMEOUT=15, dmem_ready held low:
  - expected: mem_timeout_err=1 after the 16th cycle, all en=0, and this holds;
  - after pulsing rst_n low: err=0 and counters=0.
- Counter saturation, CNT_W=4 with 20 stall cycles → stall_cycles=15.
